// File: rtl/fft_mem_sequencer_pkg.sv
// Shared definitions for the radix-2 DIT FFT blocks: defaults, FSM states, log2 helper.
package fft_mem_sequencer_pkg;

  localparam int unsigned DefaultN       = 4096;
  localparam int unsigned DefaultBflyLat = 4;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  // Ceiling log2; exact for powers of two.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// Write delay line: turns each issued address pair into a top write then a bottom write,
// BFLY_LAT+1 and BFLY_LAT+2 cycles after the issue.
module fft_wr_delay #(
  parameter int unsigned AW  = 12,
  parameter int unsigned LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_1,
  input  logic [AW-1:0] in_addr_2,
  output logic          wr_en,
  output logic [AW-1:0] address_w,
  output logic          wr_sel
);

  logic [LAT:0]  v_q;
  logic [AW-1:0] a1_q [LAT];
  logic [AW-1:0] a2_q [LAT+1];

  // Shift the pairs down the line; the last register stage drives the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      for (int i = 0; i < int'(LAT); i++) a1_q[i] <= '0;
      for (int i = 0; i <= int'(LAT); i++) a2_q[i] <= '0;
      wr_en     <= 1'b0;
      address_w <= '0;
      wr_sel    <= 1'b0;
    end else begin
      v_q     <= {v_q[LAT-1:0], in_valid};
      a1_q[0] <= in_addr_1;
      a2_q[0] <= in_addr_2;
      for (int i = 1; i < int'(LAT); i++) a1_q[i] <= a1_q[i-1];
      for (int i = 1; i <= int'(LAT); i++) a2_q[i] <= a2_q[i-1];
      // Issues are two cycles apart, so the two taps are never valid together.
      wr_en <= v_q[LAT-1] | v_q[LAT];
      if (v_q[LAT-1]) begin
        address_w <= a1_q[LAT-1];
        wr_sel    <= 1'b0;
      end else if (v_q[LAT]) begin
        address_w <= a2_q[LAT];
        wr_sel    <= 1'b1;
      end else begin
        address_w <= '0;
        wr_sel    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fft_mem_sequencer.sv
// In-place radix-2 DIT FFT address / write-enable sequencer for a 2R1W sample memory.
module fft_mem_sequencer
  import fft_mem_sequencer_pkg::*;
#(
  parameter  int unsigned N        = DefaultN,
  parameter  int unsigned BFLY_LAT = DefaultBflyLat,
  localparam int unsigned L        = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] address_1,
  output logic [L-1:0] address_2,
  output logic [L-2:0] tw_addr,
  output logic         bfly_valid,
  output logic         wr_en,
  output logic [L-1:0] address_w,
  output logic         wr_sel,
  output logic [L-1:0] stage
);

  localparam int unsigned CntW = clog2(N + BFLY_LAT + 1);
  localparam int unsigned BW   = L - 1;
  localparam logic [CntW-1:0] CntLastIssue = CntW'(N - 2);
  localparam logic [CntW-1:0] CntLastWrite = CntW'(N + BFLY_LAT);
  localparam logic [L-1:0]    StageLast    = L'(L - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;    // cycles since the stage's first issue; bit 0 is the issue phase
  logic            issue_q;

  logic [CntW-1:0] cnt_nxt;
  logic            do_issue;
  logic [L-1:0]    iss_stage;
  logic [BW-1:0]   iss_b;
  logic [L-1:0]    span, k, g, a1, a2, tw_full;

  // Butterfly selection and address arithmetic for the issue loaded at the next edge.
  always_comb begin
    cnt_nxt   = cnt_q + CntW'(1);
    iss_stage = stage;
    iss_b     = '0;
    do_issue  = 1'b0;
    case (state_q)
      StIdle: begin
        iss_stage = '0;
        do_issue  = start;
      end
      StIssue: begin
        iss_b    = BW'(cnt_nxt >> 1);
        do_issue = !cnt_nxt[0];
      end
      StDrain: begin
        iss_stage = stage + L'(1);
        do_issue  = (cnt_q == CntLastWrite) && (stage != StageLast);
      end
      default: ;
    endcase
    span    = L'(1) << iss_stage;
    k       = {1'b0, iss_b} & (span - L'(1));
    g       = {1'b0, iss_b} >> iss_stage;
    a1      = (g << (iss_stage + L'(1))) + k;
    a2      = a1 + span;
    tw_full = k << (StageLast - iss_stage);
  end

  // Control FSM with registered read-side outputs; addresses are zero on non-issue cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      issue_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      address_1  <= '0;
      address_2  <= '0;
      tw_addr    <= '0;
      bfly_valid <= 1'b0;
      stage      <= '0;
    end else begin
      issue_q    <= 1'b0;
      address_1  <= '0;
      address_2  <= '0;
      tw_addr    <= '0;
      done       <= 1'b0;
      bfly_valid <= issue_q;
      if (do_issue) begin
        issue_q   <= 1'b1;
        address_1 <= a1;
        address_2 <= a2;
        tw_addr   <= tw_full[L-2:0];
        stage     <= iss_stage;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StIssue;
            busy    <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StIssue: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt == CntLastIssue) state_q <= StDrain;
        end
        StDrain: begin
          // Hold off the next stage until the cycle after its last write.
          if (cnt_q == CntLastWrite) begin
            cnt_q <= '0;
            if (stage == StageLast) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end else begin
            cnt_q <= cnt_nxt;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fft_wr_delay #(
    .AW  (L),
    .LAT (BFLY_LAT)
  ) u_wr_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_q),
    .in_addr_1 (address_1),
    .in_addr_2 (address_2),
    .wr_en     (wr_en),
    .address_w (address_w),
    .wr_sel    (wr_sel)
  );

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Directed bench: N=8/LAT=2 cycle-exact sequence, N=16/LAT=5 hazard scoreboard,
// N=4096/LAT=4 full-length run.
module tb_fft_mem_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // DUT A: N=8, BFLY_LAT=2
  logic       busy_a, done_a, bv_a, we_a, ws_a;
  logic [2:0] a1_a, a2_a, aw_a, st_a;
  logic [1:0] tw_a;

  fft_mem_sequencer #(.N(8), .BFLY_LAT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .address_1(a1_a), .address_2(a2_a), .tw_addr(tw_a), .bfly_valid(bv_a),
    .wr_en(we_a), .address_w(aw_a), .wr_sel(ws_a), .stage(st_a)
  );

  // DUT B: N=16, BFLY_LAT=5
  logic       busy_b, done_b, bv_b, we_b, ws_b;
  logic [3:0] a1_b, a2_b, aw_b, st_b;
  logic [2:0] tw_b;

  fft_mem_sequencer #(.N(16), .BFLY_LAT(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .address_1(a1_b), .address_2(a2_b), .tw_addr(tw_b), .bfly_valid(bv_b),
    .wr_en(we_b), .address_w(aw_b), .wr_sel(ws_b), .stage(st_b)
  );

  // DUT C: N=4096, BFLY_LAT=4
  logic        busy_c, done_c, bv_c, we_c, ws_c;
  logic [11:0] a1_c, a2_c, aw_c, st_c;
  logic [10:0] tw_c;

  fft_mem_sequencer #(.N(4096), .BFLY_LAT(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .address_1(a1_c), .address_2(a2_c), .tw_addr(tw_c), .bfly_valid(bv_c),
    .wr_en(we_c), .address_w(aw_c), .wr_sel(ws_c), .stage(st_c)
  );

  // Hand-computed issue schedule for N=8, BFLY_LAT=2 with start in cycle 0.
  int ic  [12] = '{1, 3, 5, 7, 12, 14, 16, 18, 23, 25, 27, 29};
  int e1t [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int e2t [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int ett [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // {busy, done, bfly_valid, wr_en, wr_sel, stage(if busy), a1, a2, tw, address_w}
  logic [21:0] obs_a;
  assign obs_a = {busy_a, done_a, bv_a, we_a, ws_a, (busy_a ? st_a : 3'd0),
                  a1_a, a2_a, tw_a, aw_a};

  function automatic logic [21:0] exp_a(input int c);
    logic       eb, ed, ev, ewe, es;
    logic [2:0] est, e1, e2, ew;
    logic [1:0] et;
    eb = (c >= 1 && c <= 34);
    ed = (c == 34);
    est = !eb ? 3'd0 : (c < 12) ? 3'd0 : (c < 23) ? 3'd1 : 3'd2;
    ev = 1'b0; ewe = 1'b0; es = 1'b0;
    e1 = '0; e2 = '0; ew = '0; et = '0;
    for (int i = 0; i < 12; i++) begin
      if (c == ic[i]) begin
        e1 = 3'(e1t[i]); e2 = 3'(e2t[i]); et = 2'(ett[i]);
      end
      if (c == ic[i] + 1) ev = 1'b1;
      if (c == ic[i] + 3) begin ewe = 1'b1; ew = 3'(e1t[i]); es = 1'b0; end
      if (c == ic[i] + 4) begin ewe = 1'b1; ew = 3'(e2t[i]); es = 1'b1; end
    end
    return {eb, ed, ev, ewe, es, est, e1, e2, et, ew};
  endfunction

  task automatic run_a(input int n_cyc, input bit extra_starts);
    @(negedge clk);
    start_a = 1'b1;
    n_vec++;
    if (obs_a !== exp_a(0)) begin
      n_err++;
      $display("FAIL seq cycle 0: got %h expected %h", obs_a, exp_a(0));
    end
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      start_a = extra_starts && (c == 5 || c == 20);
      n_vec++;
      if (obs_a !== exp_a(c)) begin
        n_err++;
        $display("FAIL seq cycle %0d: got %h expected %h", c, obs_a, exp_a(c));
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs_a !== 22'd0) begin
      n_err++;
      $display("FAIL reset_a: got %h expected 0", obs_a);
    end
    n_vec++;
    if ({busy_b, we_b, busy_c, we_c} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_bc: got %b expected 0000", {busy_b, we_b, busy_c, we_c});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    run_a(40, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_a(40, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      n_vec++;
      if (obs_a !== exp_a(c)) begin
        n_err++;
        $display("FAIL pre_reset cycle %0d: got %h expected %h", c, obs_a, exp_a(c));
      end
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_a !== 22'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h expected 0", obs_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_vec++;
      if (obs_a !== 22'd0) begin
        n_err++;
        $display("FAIL post_reset cycle %0d: got %h expected 0", c, obs_a);
      end
    end
    run_a(40, 1'b0);
  endtask

  task automatic test_hazard();
    int          nwr, nrd, done_cyc, rs, ws;
    int          wcnt [4];
    logic [15:0] wmask [4];
    nwr = 0; nrd = 0; done_cyc = -1;
    for (int s = 0; s < 4; s++) begin wcnt[s] = 0; wmask[s] = '0; end
    @(negedge clk);
    start_b = 1'b1;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (a2_b != 4'd0) begin
        rs = nrd / 8;
        if (rs > 0 && rs < 4 && (nrd % 8) == 0) begin
          n_vec++;
          if (wcnt[rs-1] != 16) begin
            n_err++;
            $display("FAIL hazard stage %0d read at cycle %0d: prior writes %0d required 16",
                     rs, c, wcnt[rs-1]);
          end
        end
        nrd++;
      end
      if (we_b) begin
        ws = nwr / 16;
        if (ws < 4) begin
          if (wmask[ws][aw_b]) begin
            n_vec++;
            n_err++;
            $display("FAIL dup_write stage %0d addr %0d: written twice, required once", ws, aw_b);
          end
          wmask[ws][aw_b] = 1'b1;
          wcnt[ws]++;
        end
        nwr++;
      end
      if (done_b) done_cyc = c;
    end
    n_vec++;
    if (done_cyc != 89) begin
      n_err++;
      $display("FAIL done_b cycle: got %0d required 89", done_cyc);
    end
    n_vec++;
    if (nwr != 64 || nrd != 32) begin
      n_err++;
      $display("FAIL counts_b: writes %0d reads %0d required 64 32", nwr, nrd);
    end
    for (int s = 0; s < 4; s++) begin
      n_vec++;
      if (wmask[s] !== 16'hffff) begin
        n_err++;
        $display("FAIL wmask stage %0d: got %h required ffff", s, wmask[s]);
      end
    end
  endtask

  task automatic test_full_size();
    int nwr, done_cyc;
    nwr = 0; done_cyc = -1;
    @(negedge clk);
    start_c = 1'b1;
    for (int c = 1; c <= 50000 && done_cyc < 0; c++) begin
      @(negedge clk);
      start_c = 1'b0;
      if (we_c) nwr++;
      if (done_c) done_cyc = c;
    end
    n_vec++;
    if (done_cyc != 49213) begin
      n_err++;
      $display("FAIL done_c cycle: got %0d required 49213", done_cyc);
    end
    repeat (8) begin
      @(negedge clk);
      if (we_c) nwr++;
    end
    n_vec++;
    if (nwr != 12 * 4096) begin
      n_err++;
      $display("FAIL writes_c: got %0d required %0d", nwr, 12 * 4096);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_start_while_busy();
    test_mid_reset();
    test_hazard();
    test_full_size();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
